trap_dump_ctrl: RTL and testbench
=================================

// Module: trap_dump_ctrl
// PURPOSE
//   Synthesizable end-of-run controller for the DLX single-cycle/pipelined cores.
//   - Watches the retiring instruction stream.
//   - On the halt trap, or on a watchdog timeout, asserts halt to freeze the PC.
//   - Then streams a programmable window of data memory out over a valid/ready port.
//   Sits beside toplevel, between the instruction fetch unit and the spare read port of the data memory.
// PARAMETERS
//   INSTR_W     32        instruction width
//   ADDR_W      10        data-memory byte-address width
//   DATA_W      8         data-memory word width (one beat per word)
//   TRAP_WORD   32'h44000300  instruction that ends the run
//   DUMP_BASE   0         first dumped address
//   DUMP_COUNT  1024      words dumped (1..2**ADDR_W)
//   TIMEOUT     2500      watchdog limit in RUN cycles (TRAP_WATCHDOG_EN only)
//   CNT_W       16        cycle_count width
// PORTS
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   instr        in   INSTR_W  instruction currently executing
//   instr_valid  in   1        instr is valid this cycle
//   halt         out  1        freeze PC / disable RegWr, MemWr
//   mem_rd_en    out  1        data-memory read strobe
//   mem_rd_addr  out  ADDR_W   data-memory read address
//   mem_rd_data  in   DATA_W   read data, valid the cycle after mem_rd_en
//   dump_valid   out  1        dump beat valid
//   dump_ready   in   1        sink accepts beat
//   dump_data    out  DATA_W   dump beat payload
//   dump_last    out  1        final beat of dump
//   done         out  1        dump complete (sticky)
//   timeout      out  1        run ended by watchdog, not trap (sticky)
//   cycle_count  out  CNT_W    RUN cycles elapsed, saturating
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=RUN; all outputs 0; cycle_count=0; addr=DUMP_BASE.
//   - FSM states: RUN -> RD -> CAP -> SEND -> (RD | DONE).
//   - RUN:
//       - cycle_count increments each clk; holds at all-ones.
//       - Exact match instr==TRAP_WORD with instr_valid=1 in cycle N -> halt=1 from N+1, state RD.
//       - cycle_count freezes at N+1 value (trap cycle counted).
//       - instr_valid=0: instr ignored.
//   - RD: mem_rd_en=1, mem_rd_addr=addr for exactly one cycle -> CAP.
//   - CAP: capture mem_rd_data into dump_data -> SEND.
//   - SEND:
//       - dump_valid=1; dump_last=1 iff beat index==DUMP_COUNT-1.
//       - dump_data and dump_last stable while dump_ready=0.
//       - Handshake on valid&ready:
//           - last beat -> DONE.
//           - otherwise addr+1 (mod 2**ADDR_W) -> RD.
//       - Minimum 3 cycles per beat.
//   - DONE:
//       - done=1, halt=1, dump_valid=0, mem_rd_en=0.
//       - Further traps ignored; left only by reset.
//   - halt stays 1 in RD/CAP/SEND/DONE.
//   - DUMP_COUNT=1: first beat carries dump_last=1.
//   - Reset mid-dump: immediate return to RUN, beat dropped, no partial done.
//   - Trap and watchdog expiry in same cycle: trap wins, timeout=0.
// CONFIGURATION
//   TRAP_WATCHDOG_EN defined:
//     - In RUN, when cycle_count reaches TIMEOUT-1 without a trap: timeout=1, halt=1 next cycle.
//     - Dump proceeds exactly as for a trap.
//   TRAP_WATCHDOG_EN undefined:
//     - No comparator; timeout tied 0; only a trap ends RUN.
//     - TIMEOUT unused.
// TESTING
//   1. Trap 0x44000300 valid at cycle 10 -> halt=1 at 11, cycle_count=11, mem_rd_addr=0 at 11.
//   2. DUMP_COUNT=4, mem[0..3]=A1,B2,C3,D4, ready=1 -> beats A1,B2,C3,D4.
//      dump_last on D4 only; done=1 cycle after D4.
//   3. dump_ready=0 for 5 cycles on beat 2 -> dump_valid held, dump_data=C3 stable, no addr advance.
//   4. Near-miss 0x44000301, and trap with instr_valid=0 -> halt stays 0, RUN continues.
//   5. WATCHDOG_EN, TIMEOUT=20, no trap -> timeout=1, halt=1 at cycle 20, dump follows.
//      Without macro -> timeout=0, still RUN.
//   6. rst_n low during SEND of beat 1 -> async clear: halt=0, dump_valid=0, done=0.
//      Rerun dump restarts at DUMP_BASE.

Source files
------------

// File: rtl/trap_dump_ctrl.sv
// trap_dump_ctrl: end-of-run controller for the DLX cores.
// It watches retiring instructions. On the halt trap it freezes the core, and
// on a watchdog expiry (only when TRAP_WATCHDOG_EN is defined) it does the same.
// It then streams DUMP_COUNT words of data memory, starting at DUMP_BASE,
// over a valid/ready port.
// Optional feature macro: TRAP_WATCHDOG_EN (watchdog on RUN cycles).
module trap_dump_ctrl #(
    parameter int                 INSTR_W    = 32,
    parameter int                 ADDR_W     = 10,
    parameter int                 DATA_W     = 8,
    parameter logic [INSTR_W-1:0] TRAP_WORD  = 'h44000300,
    parameter int                 DUMP_BASE  = 0,
    parameter int                 DUMP_COUNT = 1024,
    parameter int                 TIMEOUT    = 2500,
    parameter int                 CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               halt,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [DATA_W-1:0]  dump_data,
    output logic               dump_last,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DUMP_COUNT - 1);

    typedef enum logic [2:0] {RUN, RD, CAP, SEND, DONE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   beat_idx;
    logic [DATA_W-1:0]   data_q;
    logic                trap_hit;
    logic                wd_hit;
    logic                is_last;

    assign trap_hit = instr_valid && (instr == TRAP_WORD);
    assign is_last  = (beat_idx == LAST_IDX);

`ifdef TRAP_WATCHDOG_EN
    logic timeout_q;

    assign wd_hit  = (cycle_count == CNT_W'(TIMEOUT - 1));
    assign timeout = timeout_q;

    // Sticky record that RUN was ended by the watchdog; a trap in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout_q <= 1'b0;
        else if (state == RUN && wd_hit && !trap_hit)
            timeout_q <= 1'b1;
    end
`else
    assign wd_hit  = 1'b0;
    // Without the watchdog, TIMEOUT has no meaning, so timeout is constant 0.
    assign timeout = (TIMEOUT < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_n;
    end

    // Next-state logic. Each beat is RD -> CAP -> SEND, so a beat takes at least 3 cycles.
    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (trap_hit || wd_hit) state_n = RD;
            RD:      state_n = CAP;
            CAP:     state_n = SEND;
            SEND:    if (dump_ready) state_n = is_last ? DONE : RD;
            DONE:    state_n = DONE;
            default: state_n = RUN;
        endcase
    end

    // Datapath: the cycle counter runs only in RUN, read data is captured in CAP,
    // and the address advances on a handshake of any beat except the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            addr        <= BASE_ADDR;
            beat_idx    <= '0;
            data_q      <= '0;
        end else begin
            case (state)
                RUN: if (cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + 1'b1;
                CAP: data_q <= mem_rd_data;
                SEND: if (dump_ready && !is_last) begin
                    addr     <= addr + 1'b1;
                    beat_idx <= beat_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halt        = (state != RUN);
    assign mem_rd_en   = (state == RD);
    // The address is gated to 0 outside RD, so every output reads 0 in reset.
    assign mem_rd_addr = (state == RD) ? addr : '0;
    assign dump_valid  = (state == SEND);
    assign dump_last   = (state == SEND) && is_last;
    assign dump_data   = data_q;
    assign done        = (state == DONE);

endmodule

// File: tb/tb_trap_dump_ctrl.sv
// Directed bench for trap_dump_ctrl with a scoreboard of expected dump beats.
// Inputs are driven on the falling edge. The beat monitor samples 1 time unit after it.
module tb_trap_dump_ctrl;

    localparam logic [31:0] TRAP = 32'h44000300;
    localparam logic [31:0] NEAR = 32'h44000301;
    localparam logic [31:0] FILL = 32'h20010001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halt, mem_rd_en, dump_valid, dump_ready, dump_last, done, timeout;
    logic [9:0]  mem_rd_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic [7:0]  dump_data;
    logic [15:0] cycle_count;

    logic [7:0]  mem [0:1023];
    logic [8:0]  exp_q [$];
    int          passed = 0;
    int          total  = 0;

    trap_dump_ctrl #(.DUMP_BASE(0), .DUMP_COUNT(4), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .halt(halt), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last), .done(done),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // The data memory has a synchronous read port: data is valid one cycle after the strobe.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_dump();
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hB2});
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b1, 8'hD4});
    endtask

    // Hold reset for two cycles, then release on a falling edge. That edge is cycle 0.
    task automatic do_reset();
        rst_n = 1'b0; instr = FILL; instr_valid = 1'b0; dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    // Scoreboard: every accepted beat is compared against the next expected entry.
    always begin
        @(negedge clk);
        #1;
        if (rst_n === 1'b1 && dump_valid === 1'b1 && dump_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("beat_data", dump_data, e[7:0]);
                check("beat_last", dump_last, e[8]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;

        // Reset state
        rst_n = 1'b0; instr = FILL; instr_valid = 1'b0; dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_halt", halt, 0);
        check("rst_done", done, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_last", dump_last, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);
        rst_n = 1'b1;

        // Near-miss trap and an invalid trap are ignored; the real trap is at cycle 10.
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2 || k == 3) begin instr = NEAR; instr_valid = 1'b1; end
            else if (k == 4 || k == 5) begin instr = TRAP; instr_valid = 1'b0; end
            else begin instr = FILL; instr_valid = 1'b1; end
            if (k == 6) begin
                check("nearmiss_halt", halt, 0);
                check("nearmiss_count", cycle_count, 6);
            end
            if (k == 10) begin
                check("pretrap_halt", halt, 0);
                instr = TRAP; instr_valid = 1'b1;
            end
        end
        @(negedge clk);  // cycle 11
        instr_valid = 1'b0;
        check("trap_halt", halt, 1);
        check("trap_count", cycle_count, 11);
        check("trap_rd_en", mem_rd_en, 1);
        check("trap_rd_addr", mem_rd_addr, 0);
        check("trap_timeout", timeout, 0);
        push_dump();

        // Beat 2 (C3) is in SEND at cycle 19; the sink stalls it for 5 cycles.
        repeat (7) @(negedge clk);  // cycle 18
        dump_ready = 1'b0;
        for (int k = 19; k <= 23; k++) begin
            @(negedge clk);
            check("stall_valid", dump_valid, 1);
            check("stall_data", dump_data, 8'hC3);
            check("stall_last", dump_last, 0);
            check("stall_rd_en", mem_rd_en, 0);
        end
        @(negedge clk);  // cycle 24
        dump_ready = 1'b1;
        repeat (3) @(negedge clk);  // cycle 27: last beat
        check("last_flag", dump_last, 1);
        check("last_data", dump_data, 8'hD4);
        @(negedge clk);  // cycle 28
        check("done_flag", done, 1);
        check("done_halt", halt, 1);
        check("done_valid", dump_valid, 0);
        check("done_rd_en", mem_rd_en, 0);
        check("sb_drained1", 32'(exp_q.size()), 0);
        instr = TRAP; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("done_sticky", done, 1);
        check("done_count_frozen", cycle_count, 11);

`ifdef TRAP_WATCHDOG_EN
        // The watchdog expires with no trap: halt and timeout rise at cycle 20.
        do_reset();
        instr_valid = 1'b1;
        for (int k = 1; k <= 19; k++) @(negedge clk);
        check("wd_pre_halt", halt, 0);
        check("wd_pre_timeout", timeout, 0);
        @(negedge clk);
        check("wd_halt", halt, 1);
        check("wd_timeout", timeout, 1);
        check("wd_count", cycle_count, 20);
        check("wd_rd_en", mem_rd_en, 1);
        push_dump();
        wait_done();
        check("wd_timeout_sticky", timeout, 1);
        check("sb_drained_wd", 32'(exp_q.size()), 0);
        // A trap in the watchdog-expiry cycle wins.
        do_reset();
        for (int k = 1; k <= 19; k++) @(negedge clk);
        instr = TRAP; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("tie_halt", halt, 1);
        check("tie_timeout", timeout, 0);
`else
        // Without the watchdog, RUN continues past TIMEOUT.
        do_reset();
        instr_valid = 1'b1;
        for (int k = 1; k <= 30; k++) @(negedge clk);
        check("nowd_halt", halt, 0);
        check("nowd_timeout", timeout, 0);
        check("nowd_count", cycle_count, 30);
        check("nowd_rd_en", mem_rd_en, 0);
`endif

        // Reset during SEND of beat 1 drops the beat; the rerun starts at DUMP_BASE.
        do_reset();
        for (int k = 1; k <= 3; k++) @(negedge clk);
        instr = TRAP; instr_valid = 1'b1;
        exp_q.push_back({1'b0, 8'hA1});
        @(negedge clk);  // cycle 4
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);  // cycle 8
        dump_ready = 1'b0;
        @(negedge clk);  // cycle 9: beat 1 held
        check("mid_valid", dump_valid, 1);
        check("mid_data", dump_data, 8'hB2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_halt", halt, 0);
        check("arst_valid", dump_valid, 0);
        check("arst_done", done, 0);
        check("arst_count", cycle_count, 0);
        check("sb_drained_mid", 32'(exp_q.size()), 0);
        @(negedge clk);
        rst_n = 1'b1; dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        instr = TRAP; instr_valid = 1'b1;
        push_dump();
        @(negedge clk);
        instr_valid = 1'b0;
        check("rerun_rd_en", mem_rd_en, 1);
        check("rerun_rd_addr", mem_rd_addr, 0);
        wait_done();
        @(negedge clk);
        check("sb_drained_rerun", 32'(exp_q.size()), 0);
        check("rerun_timeout", timeout, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
